// File: rtl/pio_edge_servicer_pkg.sv
// Shared register map and FSM state encoding for the PIO edge servicer.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_MASK    = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_CLR     = 3'd5,
    S_PUSH    = 3'd6
  } state_e;

endpackage

// File: rtl/pio_edge_servicer_event_fifo.sv
// Pointer-based event FIFO; head is presented from storage, no fall-through.
module event_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [AW:0]      count_s;
  logic             push_s;
  logic             pop_s;

  assign count_s    = wr_q - rd_q;
  assign full_o     = (count_s == (AW+1)'(DEPTH));
  assign empty_o    = (wr_q == rd_q);
  assign pop_s      = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so a push at full is accepted alongside it.
  assign push_s     = push_i && (!full_o || pop_s);
  assign pop_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pio_edge_servicer.sv
// Avalon-MM initiator that drains an edge-capturing PIO into an event stream
// and programs its interrupt mask after reset and on request.
module pio_edge_servicer
  import pio_pkg::*;
#(
  parameter int unsigned     WIDTH        = 4,
  parameter int unsigned     READ_LATENCY = 1,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [WIDTH-1:0] MASK_INIT   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [WIDTH-1:0] m_writedata,
  input  logic [WIDTH-1:0] m_readdata,
  input  logic             m_irq,
  input  logic             cfg_mask_valid,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             cfg_mask_ready,
  output logic             event_valid,
  output logic [WIDTH-1:0] event_data,
  input  logic             event_ready,
  output logic             busy
);

  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e           state_q, state_d;
  logic             init_wr_q;
  logic [LAT_W-1:0] lat_q;
  logic             lat_last_s;
  logic [WIDTH-1:0] cap_q;
  logic             cs_q, wn_q, busy_q;
  logic [1:0]       addr_q;
  logic [WIDTH-1:0] wd_q;
  logic             fifo_full_s, fifo_empty_s;

  assign lat_last_s     = (lat_q == LAT_W'(READ_LATENCY - 1));
  assign cfg_mask_ready = (state_q == S_IDLE) && cfg_mask_valid;
  assign m_chipselect   = cs_q;
  assign m_write_n      = wn_q;
  assign m_address      = addr_q;
  assign m_writedata    = wd_q;
  assign busy           = busy_q;
  assign event_valid    = !fifo_empty_s;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      // INIT holds for one extra cycle so its write is visible after reset release.
      S_INIT:    if (init_wr_q) state_d = S_IDLE; else state_d = S_INIT;
      S_IDLE: begin
        if (cfg_mask_valid)                state_d = S_MASK;
        else if (m_irq && !fifo_full_s)    state_d = S_RD_ADDR;
        else                               state_d = S_IDLE;
      end
      S_MASK:    state_d = S_IDLE;
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (!lat_last_s)                   state_d = S_RD_WAIT;
        else if (m_readdata == {WIDTH{1'b0}}) state_d = S_IDLE;
        else                               state_d = S_CLR;
      end
      S_CLR:     state_d = S_PUSH;
      S_PUSH:    state_d = S_IDLE;
      default:   state_d = S_INIT;
    endcase
  end

  // State, capture and bus registers; bus outputs are decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      init_wr_q <= 1'b0;
      lat_q     <= {LAT_W{1'b0}};
      cap_q     <= {WIDTH{1'b0}};
      busy_q    <= 1'b1;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      addr_q    <= PIO_ADDR_DATA;
      wd_q      <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      init_wr_q <= 1'b1;
      busy_q    <= (state_d != S_IDLE);
      if (state_q == S_RD_WAIT && state_d == S_RD_WAIT) lat_q <= lat_q + LAT_W'(1);
      else                                              lat_q <= {LAT_W{1'b0}};
      if (state_q == S_RD_WAIT && lat_last_s) cap_q <= m_readdata;
      case (state_d)
        S_INIT:    begin cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= PIO_ADDR_MASK; wd_q <= MASK_INIT;  end
        S_MASK:    begin cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= PIO_ADDR_MASK; wd_q <= cfg_mask;   end
        S_RD_ADDR: begin cs_q <= 1'b1; wn_q <= 1'b1; addr_q <= PIO_ADDR_EDGE; wd_q <= {WIDTH{1'b0}}; end
        S_RD_WAIT: begin cs_q <= 1'b0; wn_q <= 1'b1; addr_q <= PIO_ADDR_EDGE; wd_q <= {WIDTH{1'b0}}; end
        // Clear exactly the bits just read; later edges on other bits survive.
        S_CLR:     begin cs_q <= 1'b1; wn_q <= 1'b0; addr_q <= PIO_ADDR_EDGE; wd_q <= m_readdata; end
        default:   begin cs_q <= 1'b0; wn_q <= 1'b1; addr_q <= PIO_ADDR_DATA; wd_q <= {WIDTH{1'b0}}; end
      endcase
    end
  end

  event_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (state_q == S_PUSH),
    .push_data_i (cap_q),
    .pop_i       (event_ready),
    .pop_data_o  (event_data),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

endmodule

// File: tb/tb_pio_edge_servicer.sv
// Directed bench for pio_edge_servicer with a behavioural edge-capture PIO model.
module tb_pio_edge_servicer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] m_address;
  logic       m_chipselect, m_write_n;
  logic [3:0] m_writedata, m_readdata;
  logic       m_irq;
  logic       cfg_mask_valid;
  logic [3:0] cfg_mask;
  logic       cfg_mask_ready;
  logic       event_valid;
  logic [3:0] event_data;
  logic       event_ready;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pio_edge_servicer #(
    .WIDTH(4), .READ_LATENCY(1), .DEPTH(4), .MASK_INIT(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_irq(m_irq),
    .cfg_mask_valid(cfg_mask_valid), .cfg_mask(cfg_mask), .cfg_mask_ready(cfg_mask_ready),
    .event_valid(event_valid), .event_data(event_data), .event_ready(event_ready),
    .busy(busy)
  );

  // Peripheral model: registered readdata, W1C edge capture with clear priority.
  logic [3:0] pm_edge = 4'd0;
  logic [3:0] pm_mask = 4'd0;
  logic [3:0] pm_rd   = 4'd0;
  logic       pm_frc  = 1'b0;
  logic [3:0] inj     = 4'd0;
  logic       frc     = 1'b0;

  assign m_readdata = pm_rd;
  assign m_irq      = (|(pm_edge & pm_mask)) | pm_frc;

  always @(posedge clk) begin
    if (m_chipselect && !m_write_n && m_address == 2'd2) pm_mask <= m_writedata;
    if (m_chipselect && m_write_n) begin
      case (m_address)
        2'd2:    pm_rd <= pm_mask;
        2'd3:    pm_rd <= pm_edge;
        default: pm_rd <= 4'd0;
      endcase
    end
    pm_edge <= (pm_edge | inj) &
               ((m_chipselect && !m_write_n && m_address == 2'd3) ? ~m_writedata : 4'hF);
    pm_frc  <= frc;
  end

  logic [7:0] bus;
  assign bus = {m_chipselect, m_write_n, m_address, m_writedata};

  typedef struct {
    logic [3:0] edge_v;
    logic       spur;
    logic [7:0] exp_clr;
    logic [4:0] exp_evt;
  } vec_t;

  vec_t       vt [5];
  logic [3:0] fill [4];
  logic [3:0] drain [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Edge lands at the posedge between the two negedges; returns mid-cycle T.
  task automatic inject(input logic [3:0] v, input logic f);
    @(negedge clk); inj = v; frc = f;
    @(negedge clk); inj = 4'd0; frc = 1'b0;
  endtask

  task automatic pop_one();
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
  endtask

  initial begin
    vt[0] = '{4'b0010, 1'b0, 8'b1011_0010, 5'b1_0010};
    vt[1] = '{4'b1000, 1'b0, 8'b1011_1000, 5'b1_1000};
    vt[2] = '{4'b0101, 1'b0, 8'b1011_0101, 5'b1_0101};
    vt[3] = '{4'b1111, 1'b0, 8'b1011_1111, 5'b1_1111};
    vt[4] = '{4'b0000, 1'b1, 8'b0100_0000, 5'b0_0000};
    fill[0] = 4'b0001; fill[1] = 4'b0010; fill[2] = 4'b0100; fill[3] = 4'b1000;
    drain[0] = 4'b0010; drain[1] = 4'b0100; drain[2] = 4'b1000; drain[3] = 4'b0001;

    reset_n = 1'b0; cfg_mask_valid = 1'b0; cfg_mask = 4'd0; event_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bus", bus, 8'b0100_0000);
    check("rst_ready", cfg_mask_ready, 1'b0);
    check("rst_event", {event_valid, event_data}, 5'b0_0000);
    check("rst_busy", busy, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check("init_write", bus, 8'b1010_1111);
    check("init_busy", busy, 1'b1);
    @(negedge clk);
    check("init_idle_bus", bus, 8'b0100_0000);
    check("init_idle_busy", busy, 1'b0);
    check("init_mask", pm_mask, 4'hF);

    for (int i = 0; i < 5; i++) begin
      inject(vt[i].edge_v, vt[i].spur);
      check("irq_seen", m_irq, 1'b1);
      @(negedge clk); check("rd_strobe", bus, 8'b1111_0000);
      @(negedge clk); check("rd_wait", bus, 8'b0111_0000);
      @(negedge clk); check("clr_write", bus, vt[i].exp_clr);
      @(negedge clk); check("edge_cleared", pm_edge, 4'd0);
      @(negedge clk);
      check("event", {event_valid, event_data}, vt[i].exp_evt);
      check("busy_done", busy, 1'b0);
      if (vt[i].exp_evt[4]) pop_one();
      check("drained", event_valid, 1'b0);
    end

    // FIFO full: fifth irq stays pending until a slot frees.
    for (int k = 0; k < 4; k++) begin
      inject(fill[k], 1'b0);
      repeat (5) @(negedge clk);
    end
    check("full_head", {event_valid, event_data}, 5'b1_0001);
    inject(4'b0001, 1'b0);
    repeat (6) @(negedge clk);
    check("full_irq_pending", m_irq, 1'b1);
    check("full_not_busy", busy, 1'b0);
    check("full_edge_kept", pm_edge, 4'b0001);
    pop_one();
    repeat (6) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("full_drain", {event_valid, event_data}, {1'b1, drain[k]});
      pop_one();
    end
    check("full_empty", event_valid, 1'b0);
    check("full_irq_clear", m_irq, 1'b0);

    // Mask request and irq in the same IDLE cycle: mask write wins.
    inject(4'b0001, 1'b0);
    cfg_mask_valid = 1'b1; cfg_mask = 4'b0101;
    #1 check("mask_ready", cfg_mask_ready, 1'b1);
    @(negedge clk);
    cfg_mask_valid = 1'b0;
    check("mask_write", bus, 8'b1010_0101);
    check("mask_ready_pulse", cfg_mask_ready, 1'b0);
    @(negedge clk);
    check("mask_applied", pm_mask, 4'b0101);
    @(negedge clk); check("mask_then_rd", bus, 8'b1111_0000);
    repeat (2) @(negedge clk); check("mask_then_clr", bus, 8'b1011_0001);
    repeat (2) @(negedge clk); check("mask_then_event", {event_valid, event_data}, 5'b1_0001);
    pop_one();

    // Reset asserted during CLR: FIFO flushed, INIT reruns, pending edge re-serviced.
    inject(4'b0001, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_rst_queued", event_valid, 1'b1);
    inject(4'b0100, 1'b0);
    repeat (3) @(negedge clk);
    check("clr_before_rst", bus, 8'b1011_0100);
    reset_n = 1'b0;
    #1;
    check("midrst_bus", bus, 8'b0100_0000);
    check("midrst_busy", busy, 1'b1);
    check("midrst_event", {event_valid, event_data}, 5'b0_0000);
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_edge_kept", pm_edge, 4'b0100);
    @(negedge clk);
    check("reinit_write", bus, 8'b1010_1111);
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("post_rst_event", {event_valid, event_data}, 5'b1_0100);
    pop_one();
    check("post_rst_empty", event_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
